// File: rtl/data_ram_if.sv
// ----------------------------------------------------------------------------
// data_ram_if
//   Data-port bundle between the CPU top (master) and the data memory (slave).
//   Handshake: there is none. A request (data_re / data_we) is accepted on
//   every rising edge where it is high, and the CPU never waits. Read data
//   appears on data_rdata the cycle after data_re.
// Signals
//   data_re     master->slave  read request this cycle
//   data_raddr  master->slave  read byte address
//   data_rdata  slave->master  read data, one cycle after data_re
//   data_we     master->slave  write request this cycle
//   data_waddr  master->slave  write byte address
//   data_wdata  master->slave  write data, byte lane i = bits [8i+7:8i]
//   data_wstrb  master->slave  byte-lane write enables
// ----------------------------------------------------------------------------
interface data_ram_if;
    logic        data_re;
    logic [31:0] data_raddr;
    logic [31:0] data_rdata;
    logic        data_we;
    logic [31:0] data_waddr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;

    modport master (
        output data_re, data_raddr, data_we, data_waddr, data_wdata, data_wstrb,
        input  data_rdata
    );

    modport slave (
        input  data_re, data_raddr, data_we, data_waddr, data_wdata, data_wstrb,
        output data_rdata
    );
endinterface

// File: rtl/data_ram_sync.sv
// ----------------------------------------------------------------------------
// data_ram_sync
//   Word-organised data memory behind the CPU data port. One registered read
//   port (latency 1) and one byte-strobed write port, with range checking, an
//   out-of-range error pulse and read/write access counters.
//   Optional macro DATA_RAM_BYPASS_EN: a same-cycle read and write to the same
//   word returns the merged (write-first) word. Without it the read returns
//   the pre-write contents (read-first) and the array is plain block RAM.
// Parameters
//   ADDR_W     word-index width, DEPTH = 2**ADDR_W words
//   INIT_FILE  hex image name (reserved)
//   CNT_W      access counter width
// Ports
//   clk      clock, rising edge
//   rst      asynchronous reset, active-high
//   bus      data port (data_ram_if.slave)
//   acc_err  one-cycle pulse after an edge with an out-of-range access
//   rd_cnt   accepted in-range reads since reset (wraps)
//   wr_cnt   accepted in-range writes with wstrb!=0 since reset (wraps)
// ----------------------------------------------------------------------------
module data_ram_sync #(
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = "",
    parameter int    CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_if.slave        bus,
    output logic             acc_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ridx;
    logic [ADDR_W-1:0] widx;
    logic              rd_in_range;
    logic              wr_in_range;
    logic              rd_ok;
    logic              wr_ok;
    logic              err_next;
    logic [31:0]       rd_word;
    logic [31:0]       rd_next;
    logic              unused_addr_bits;

    // Byte offset within a word plays no part in word addressing.
    assign unused_addr_bits = ^{bus.data_raddr[1:0], bus.data_waddr[1:0]};

    assign ridx        = bus.data_raddr[ADDR_W+1:2];
    assign widx        = bus.data_waddr[ADDR_W+1:2];
    assign rd_in_range = (bus.data_raddr[31:ADDR_W+2] == '0);
    assign wr_in_range = (bus.data_waddr[31:ADDR_W+2] == '0);
    assign rd_ok       = bus.data_re & rd_in_range;
    // A write with no lanes enabled changes nothing and is not counted.
    assign wr_ok       = bus.data_we & wr_in_range & (|bus.data_wstrb);
    // Out-of-range flags regardless of strobes: the address itself is bad.
    assign err_next    = (bus.data_re & ~rd_in_range) | (bus.data_we & ~wr_in_range);

`ifdef DATA_RAM_BYPASS_EN
    logic same_word;
    assign same_word = (ridx == widx);

    // Write-first: lanes being written this edge come from data_wdata.
    always_comb begin
        rd_word = mem[ridx];
        if (wr_ok && same_word) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_wstrb[i]) begin
                    rd_word[8*i +: 8] = bus.data_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    // Read-first: the array value before this edge's write.
    always_comb begin
        rd_word = mem[ridx];
    end
`endif

    always_comb begin
        rd_next = rd_ok ? rd_word : 32'h0;
    end

    // Array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_wstrb[i]) begin
                    mem[widx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_rdata <= 32'h0;
            acc_err        <= 1'b0;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
        end else begin
            bus.data_rdata <= rd_next;
            acc_err        <= err_next;
            if (rd_ok) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (wr_ok) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_ram_sync.sv
// ----------------------------------------------------------------------------
// tb_data_ram_sync
//   Self-checking bench for data_ram_sync (ADDR_W=12, CNT_W=4). Directed
//   scenarios followed by randomized traffic, all compared against a word
//   array reference model with per-byte "known" masks.
// ----------------------------------------------------------------------------
module tb_data_ram_sync;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic             clk;
    logic             rst;
    logic             acc_err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    data_ram_if bus ();

    data_ram_sync #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (""),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .acc_err (acc_err),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    logic [31:0]      m_mem   [DEPTH];
    logic [3:0]       m_known [DEPTH];
    logic [CNT_W-1:0] m_rd;
    logic [CNT_W-1:0] m_wr;
    logic [31:0]      exp_q [$];
    logic [31:0]      msk_q [$];
    int               n_checks;
    int               n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = k[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return (a >> (ADDR_W + 2)) == 0;
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of requests, predicts the outcome from the model,
    // then samples #1 after the edge and checks.
    task automatic do_cycle(input logic re, input logic [31:0] ra,
                            input logic we, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [3:0] ws);
        int          ri;
        int          wi;
        logic [31:0] e_rd;
        logic [3:0]  e_k;
        logic        e_err;
        logic [31:0] got_exp;
        logic [31:0] got_msk;

        bus.data_re    = re;
        bus.data_raddr = ra;
        bus.data_we    = we;
        bus.data_waddr = wa;
        bus.data_wdata = wd;
        bus.data_wstrb = ws;

        ri    = int'((ra >> 2) % DEPTH);
        wi    = int'((wa >> 2) % DEPTH);
        e_rd  = 32'h0;
        e_k   = 4'hF;
        if (re && in_range(ra)) begin
            e_rd = m_mem[ri];
            e_k  = m_known[ri];
`ifdef DATA_RAM_BYPASS_EN
            if (we && in_range(wa) && ws != 4'h0 && wi == ri) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[b]) begin
                        e_rd[8*b +: 8] = wd[8*b +: 8];
                        e_k[b]         = 1'b1;
                    end
                end
            end
`endif
        end
        e_err = (re && !in_range(ra)) || (we && !in_range(wa));

        if (we && in_range(wa)) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) begin
                    m_mem[wi][8*b +: 8] = wd[8*b +: 8];
                    m_known[wi][b]      = 1'b1;
                end
            end
        end
        if (re && in_range(ra))                  m_rd = m_rd + 1'b1;
        if (we && in_range(wa) && ws != 4'h0)    m_wr = m_wr + 1'b1;
        exp_q.push_back(e_rd);
        msk_q.push_back(lane_mask(e_k));

        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        got_msk = msk_q.pop_front();
        check_val("rdata",   bus.data_rdata & got_msk, got_exp & got_msk);
        check_val("acc_err", {31'h0, acc_err}, {31'h0, e_err});
        check_val("rd_cnt",  {28'h0, rd_cnt},  {28'h0, m_rd});
        check_val("wr_cnt",  {28'h0, wr_cnt},  {28'h0, m_wr});
    endtask

    task automatic idle();
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        do_cycle(1'b0, 32'h0, 1'b1, a, d, s);
    endtask

    task automatic rd(input logic [31:0] a);
        do_cycle(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Async assert away from the edge, hold n edges, release away from the edge.
    task automatic apply_reset(input int n);
        bus.data_re = 1'b0;
        bus.data_we = 1'b0;
        bus.data_wstrb = 4'h0;
        rst = 1'b1;
        #1;
        m_rd = '0;
        m_wr = '0;
        check_val("rst_rdata",   bus.data_rdata, 32'h0);
        check_val("rst_acc_err", {31'h0, acc_err}, 32'h0);
        check_val("rst_rd_cnt",  {28'h0, rd_cnt}, 32'h0);
        check_val("rst_wr_cnt",  {28'h0, wr_cnt}, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        check_val("rst_hold_rdata", bus.data_rdata, 32'h0);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] a2;
        n_checks = 0;
        n_errors = 0;
        m_rd = '0;
        m_wr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 32'h0;
            m_known[i] = 4'h0;
        end
        bus.data_re = 1'b0;
        bus.data_raddr = 32'h0;
        bus.data_we = 1'b0;
        bus.data_waddr = 32'h0;
        bus.data_wdata = 32'h0;
        bus.data_wstrb = 4'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply_reset(2);

        // Full-word write then read.
        wr(32'h100, 32'hDEADBEEF, 4'hF);
        rd(32'h100);
        check_val("t2_rdata",  bus.data_rdata, 32'hDEADBEEF);
        check_val("t2_wr_cnt", {28'h0, wr_cnt}, 32'h1);
        check_val("t2_rd_cnt", {28'h0, rd_cnt}, 32'h1);

        // Byte strobes, including an all-zero strobe no-op.
        wr(32'h100, 32'h000000AA, 4'b0001);
        wr(32'h100, 32'h55000000, 4'b1000);
        wr(32'h100, 32'hFFFFFFFF, 4'b0000);
        check_val("t3_wr_cnt", {28'h0, wr_cnt}, 32'h3);
        rd(32'h101);
        check_val("t3_rdata", bus.data_rdata, 32'h55ADBEAA);

        // Same-word collision.
        wr(32'h200, 32'h11223344, 4'hF);
        do_cycle(1'b1, 32'h200, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0011);
`ifdef DATA_RAM_BYPASS_EN
        check_val("t4_collide", bus.data_rdata, 32'h1122CCDD);
`else
        check_val("t4_collide", bus.data_rdata, 32'h11223344);
`endif
        rd(32'h200);
        check_val("t4_after", bus.data_rdata, 32'h1122CCDD);

        // Reset mid-stream with a read in flight.
        bus.data_re = 1'b1;
        bus.data_raddr = 32'h200;
        @(posedge clk);
        #1;
        apply_reset(3);
        rd(32'h200);
        check_val("t1_keep200", bus.data_rdata, 32'h1122CCDD);
        rd(32'h100);
        check_val("t1_keep100", bus.data_rdata, 32'h55ADBEAA);

        // Range boundary.
        wr(32'h4000, 32'hCAFEF00D, 4'hF);
        check_val("t5_werr", {31'h0, acc_err}, 32'h1);
        rd(32'h4000);
        check_val("t5_rdata", bus.data_rdata, 32'h0);
        check_val("t5_rerr",  {31'h0, acc_err}, 32'h1);
        idle();
        check_val("t5_err_clr", {31'h0, acc_err}, 32'h0);
        wr(32'h3FFC, 32'h0BADC0DE, 4'hF);
        rd(32'h3FFC);
        check_val("t5_top", bus.data_rdata, 32'h0BADC0DE);
        rd(32'h0000_0000 | 32'h4000);
        check_val("t5_alias0", {31'h0, acc_err}, 32'h1);
        rd(32'h0);

        // Idle read gives zero.
        idle();
        check_val("t6_idle", bus.data_rdata, 32'h0);

        // Randomized traffic over a small word pool so collisions are frequent.
        for (int i = 0; i < 16; i++) wr(32'h400 + 32'(i * 4), $urandom, 4'hF);
        for (int n = 0; n < 400; n++) begin
            a  = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            a2 = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a  = 32'h4000 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) a2 = 32'h8000_0000 | 32'($urandom);
            if ($urandom_range(0, 3) == 0)  a2 = a;
            do_cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), a2,
                     $urandom, 4'($urandom_range(0, 15)));
        end

        // Counter wrap: 17 reads from reset on a 4-bit counter.
        @(posedge clk);
        #1;
        apply_reset(1);
        for (int i = 0; i < 17; i++) rd(32'h400);
        check_val("t6_wrap", {28'h0, rd_cnt}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
